// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_pkg
//  Description : Shared types and digit limits for the mm:ss BCD stopwatch.
//  Revision    : 1.0  initial release
// ============================================================================
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t DIGIT_MAX    = 4'd9;
    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t MIN_TENS_MAX = 4'd5;

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/bcd_digit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_counter
//  Description : One BCD digit counting 0..MAX with a combinational carry-out.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter bcd_t MAX = 4'd9
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output bcd_t q,
    output logic carry
);

    bcd_t r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc) begin
            r_q <= (r_q == MAX) ? '0 : r_q + 4'd1;
        end
    end

    assign q     = r_q;
    assign carry = inc & (r_q == MAX);

endmodule : bcd_digit_counter
`default_nettype wire

// File: rtl/stopwatch_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_bcd
//  Description : mm:ss BCD stopwatch advanced by rising edges of tick_in.
//  Revision    : 1.0  initial release
// ============================================================================
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_in,
    input  logic start,
    input  logic stop,
    input  logic clear,
    output bcd_t sec_ones,
    output bcd_t sec_tens,
    output bcd_t min_ones,
    output bcd_t min_tens,
    output logic running,
    output logic wrap
);

    localparam int               PRE_W    = $clog2(TICKS_PER_SEC + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);

    sw_state_t        r_state;
    sw_state_t        w_next_state;
    logic             r_tick_q;
    logic             r_running;
    logic             r_wrap;
    logic [PRE_W-1:0] r_pre;
    logic             w_tick_rise;
    logic             w_count;
    logic             w_sec_inc;
    logic             w_c_so;
    logic             w_c_st;
    logic             w_c_mo;
    logic             w_c_mt;

    assign w_tick_rise = tick_in & ~r_tick_q;

    // clear and stop both suppress an edge arriving in the same cycle
    assign w_count   = (r_state == RUN) & w_tick_rise & ~clear & ~stop;
    assign w_sec_inc = w_count & (r_pre == PRE_LAST);

    always_comb begin
        w_next_state = r_state;
        if (clear) begin
            w_next_state = IDLE;
        end else if (stop) begin
            if (r_state == RUN) begin
                w_next_state = PAUSE;
            end
        end else if (start) begin
            if (r_state != RUN) begin
                w_next_state = RUN;
            end
        end
    end

    // tick_q starts high so a level already high out of reset is not an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_tick_q  <= 1'b1;
            r_running <= 1'b0;
            r_wrap    <= 1'b0;
            r_pre     <= '0;
        end else begin
            r_state   <= w_next_state;
            r_tick_q  <= tick_in;
            r_running <= (w_next_state == RUN);
            r_wrap    <= w_c_mt;
            if (clear) begin
                r_pre <= '0;
            end else if (w_count) begin
                r_pre <= (r_pre == PRE_LAST) ? '0 : r_pre + 1'b1;
            end
        end
    end

    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_sec_ones (
        .clk(clk), .rst(rst), .clr(clear), .inc(w_sec_inc), .q(sec_ones), .carry(w_c_so)
    );

    bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .rst(rst), .clr(clear), .inc(w_c_so), .q(sec_tens), .carry(w_c_st)
    );

    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_min_ones (
        .clk(clk), .rst(rst), .clr(clear), .inc(w_c_st), .q(min_ones), .carry(w_c_mo)
    );

    bcd_digit_counter #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk(clk), .rst(rst), .clr(clear), .inc(w_c_mo), .q(min_tens), .carry(w_c_mt)
    );

    assign running = r_running;
    assign wrap    = r_wrap;

endmodule : stopwatch_bcd
`default_nettype wire

// File: tb/tb_stopwatch_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_bcd
//  Description : Scoreboard bench for stopwatch_bcd at 1 and 4 ticks per second.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stopwatch_bcd;

    typedef struct packed {
        logic [3:0] mt;
        logic [3:0] mo;
        logic [3:0] st;
        logic [3:0] so;
        logic       run;
        logic       wrp;
    } obs_t;

    typedef struct packed {
        obs_t e1;
        obs_t e4;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick_in = 1'b1;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic clear = 1'b0;

    logic [3:0] a_so, a_st, a_mo, a_mt, b_so, b_st, b_mo, b_mt;
    logic       a_run, a_wrap, b_run, b_wrap;
    obs_t       obs1, obs4;

    int pass_cnt  = 0;
    int check_cnt = 0;

    exp_t exp_q[$];

    // reference model: elapsed seconds as a plain integer, state as 0=idle 1=run 2=pause
    int m_total [2];
    int m_pre   [2];
    int m_st    [2];
    bit m_wrap  [2];
    int m_tps   [2] = '{1, 4};
    bit m_prev;

    always #5 clk = ~clk;

    stopwatch_bcd #(.TICKS_PER_SEC(1)) dut1 (
        .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .stop(stop), .clear(clear),
        .sec_ones(a_so), .sec_tens(a_st), .min_ones(a_mo), .min_tens(a_mt),
        .running(a_run), .wrap(a_wrap)
    );

    stopwatch_bcd #(.TICKS_PER_SEC(4)) dut4 (
        .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .stop(stop), .clear(clear),
        .sec_ones(b_so), .sec_tens(b_st), .min_ones(b_mo), .min_tens(b_mt),
        .running(b_run), .wrap(b_wrap)
    );

    always_comb begin
        obs1 = {a_mt, a_mo, a_st, a_so, a_run, a_wrap};
        obs4 = {b_mt, b_mo, b_st, b_so, b_run, b_wrap};
    end

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_total[k] = 0;
            m_pre[k]   = 0;
            m_st[k]    = 0;
            m_wrap[k]  = 1'b0;
        end
        m_prev = 1'b1;
    endtask

    function automatic obs_t model_obs(int k);
        obs_t o;
        int   secs;
        int   mins;
        secs  = m_total[k] % 60;
        mins  = m_total[k] / 60;
        o.so  = 4'(secs % 10);
        o.st  = 4'(secs / 10);
        o.mo  = 4'(mins % 10);
        o.mt  = 4'(mins / 10);
        o.run = (m_st[k] == 1);
        o.wrp = m_wrap[k];
        return o;
    endfunction

    task automatic model_step(bit s, bit p, bit c, bit t);
        bit rose;
        rose   = t && !m_prev;
        m_prev = t;
        for (int k = 0; k < 2; k++) begin
            m_wrap[k] = 1'b0;
            if (c) begin
                m_total[k] = 0;
                m_pre[k]   = 0;
                m_st[k]    = 0;
            end else if (p) begin
                if (m_st[k] == 1) m_st[k] = 2;
            end else begin
                if (m_st[k] == 1 && rose) begin
                    m_pre[k]++;
                    if (m_pre[k] == m_tps[k]) begin
                        m_pre[k] = 0;
                        m_total[k]++;
                        if (m_total[k] == 3600) begin
                            m_total[k] = 0;
                            m_wrap[k]  = 1'b1;
                        end
                    end
                end
                if (s && m_st[k] != 1) m_st[k] = 1;
            end
        end
    endtask

    task automatic drive(bit s, bit p, bit c, bit t);
        exp_t e;
        @(negedge clk);
        start   = s;
        stop    = p;
        clear   = c;
        tick_in = t;
        model_step(s, p, c, t);
        e.e1 = model_obs(0);
        e.e4 = model_obs(1);
        exp_q.push_back(e);
    endtask

    task automatic tick_edges(int n);
        repeat (n) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1);
            drive(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic check(string name, obs_t act, obs_t req);
        check_cnt++;
        if (act === req) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s at %0t: actual mm:ss=%h%h:%h%h run=%b wrap=%b, required mm:ss=%h%h:%h%h run=%b wrap=%b",
                     name, $time, act.mt, act.mo, act.st, act.so, act.run, act.wrp,
                     req.mt, req.mo, req.st, req.so, req.run, req.wrp);
        end
    endtask

    // monitor: one expected snapshot per clocked cycle, popped just after the edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("tps1_outputs", obs1, e.e1);
            check("tps4_outputs", obs4, e.e4);
        end
    end

    task automatic async_reset_check();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("tps1_async_reset", obs1, '0);
        check("tps4_async_reset", obs4, '0);
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // tick_in already high out of reset must not count
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick_edges(10);

        // full hour to exercise the 59:59 rollover and single-cycle wrap
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick_edges(3599);
        tick_edges(2);

        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick_edges(7);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        tick_edges(5);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick_edges(3);

        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick_edges(83);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick_edges(4);

        // prescaler must hold across a pause
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick_edges(2);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick_edges(2);

        drive(1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick_edges(5);

        async_reset_check();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick_edges(6);

        repeat (4000) begin
            int r;
            r = int'($urandom_range(0, 99));
            drive(r < 5, r >= 5 && r < 8, r == 8 || r == 9, 1'($urandom_range(0, 1)));
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        check_cnt++;
        if (exp_q.size() == 0) begin
            pass_cnt++;
        end else begin
            $display("FAIL scoreboard_drain: actual %0d pending, required 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule : tb_stopwatch_bcd
`default_nettype wire
